// File: rtl/tage_ctrl.sv
// Branch sequencer for NUM_TABLES tagged TAGE tables: lookup, final prediction, outcome wait, update/alloc strobes.
// Optional TAGE_ALLOC_LFSR_EN: LFSR-driven choice between the two lowest allocation candidates.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

package tage_ctrl_pkg;
  typedef enum logic [1:0] {
    INIT    = 2'd0,
    USER    = 2'd1,
    SUPER   = 2'd2,
    MACHINE = 2'd3
  } domain_t;
endpackage

module tage_ctrl
  import tage_ctrl_pkg::*;
#(
  parameter int NUM_TABLES = 4,
  parameter int IDX_W      = `TAGE_IDX_WIDTH,
  parameter int TAG_W      = 9,
  parameter int PW         = $clog2(NUM_TABLES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // Request handshake: a request is accepted on a cycle where req_valid_i && req_ready_o.
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [NUM_TABLES*IDX_W-1:0] req_idx_i,
  input  logic [NUM_TABLES*TAG_W-1:0] req_tag_i,
  input  domain_t                     req_domain_i,
  input  logic                        base_pred_i,
  output logic                        pred_valid_o,
  output logic                        pred_taken_o,
  output logic [PW-1:0]               pred_provider_o,
  input  logic                        res_valid_i,
  input  logic                        res_taken_i,
  input  logic                        flush_i,
  output logic [NUM_TABLES*IDX_W-1:0] tbl_hash_idx_o,
  output logic [NUM_TABLES*TAG_W-1:0] tbl_hash_tag_o,
  output domain_t                     tbl_domain_o,
  output logic                        tbl_br_result_o,
  output logic [NUM_TABLES-1:0]       tbl_provider_o,
  output logic [NUM_TABLES-1:0]       tbl_update_u_o,
  output logic [NUM_TABLES-1:0]       tbl_dec_u_o,
  output logic [NUM_TABLES-1:0]       tbl_alloc_o,
  input  logic [NUM_TABLES-1:0]       tbl_tag_hit_i,
  input  logic [NUM_TABLES-1:0]       tbl_pred_i,
  input  logic [2*NUM_TABLES-1:0]     tbl_u_i,
  input  logic [NUM_TABLES-1:0]       tbl_new_entry_i,
  output logic [2:0]                  dbg_state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_PREDICT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [NUM_TABLES*IDX_W-1:0] idx_q;
  logic [NUM_TABLES*TAG_W-1:0] tag_q;
  domain_t                     dom_q;
  logic                        base_q;
  logic [PW-1:0]               prov_id_q;
  logic                        prov_pred_q;
  logic                        alt_pred_q;
  logic                        prov_new_q;
  logic [2*NUM_TABLES-1:0]     u_q;
  logic                        pred_valid_q;
  logic                        pred_taken_q;
  logic [PW-1:0]               pred_provider_q;
  logic                        outcome_q;
  logic [3:0]                  use_alt_q, use_alt_d;

  logic [PW-1:0]         p_id_c;
  logic                  p_pred_c;
  logic                  a_pred_c;
  logic                  p_new_c;
  logic                  final_c;
  logic [NUM_TABLES-1:0] cand_c, above_c, lowest_c, rest_c, second_c, pick_c;
  logic                  upd_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_valid_i) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = flush_i ? S_IDLE : S_PREDICT;
      S_PREDICT: state_d = flush_i ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (flush_i)          state_d = S_IDLE;
        else if (res_valid_i) state_d = S_UPDATE;
      end
      S_UPDATE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Ascending scan: each new hit demotes the previous provider (or base) to alternate.
  always_comb begin
    p_id_c   = '0;
    p_pred_c = base_q;
    a_pred_c = base_q;
    p_new_c  = 1'b0;
    for (int k = 0; k < NUM_TABLES; k++) begin
      if (tbl_tag_hit_i[k]) begin
        a_pred_c = p_pred_c;
        p_id_c   = PW'(k + 1);
        p_pred_c = tbl_pred_i[k];
        p_new_c  = tbl_new_entry_i[k];
      end
    end
    final_c = (p_new_c && use_alt_q[3]) ? a_pred_c : p_pred_c;
  end

  assign upd_c = (state_q == S_UPDATE);

  always_comb begin
    use_alt_d = use_alt_q;
    if (upd_c && prov_id_q != '0 && prov_new_q && prov_pred_q != alt_pred_q) begin
      if (alt_pred_q == outcome_q) begin
        if (use_alt_q != 4'd15) use_alt_d = use_alt_q + 4'd1;
      end else begin
        if (use_alt_q != 4'd0) use_alt_d = use_alt_q - 4'd1;
      end
    end
  end

`ifdef TAGE_ALLOC_LFSR_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  // Candidates lie strictly above the provider; base provider (id 0) admits every table.
  always_comb begin
    cand_c  = '0;
    above_c = '0;
    for (int j = 0; j < NUM_TABLES; j++) begin
      if (PW'(j) >= prov_id_q) begin
        above_c[j] = 1'b1;
        if (u_q[2*j +: 2] == 2'b00) cand_c[j] = 1'b1;
      end
    end
    lowest_c = cand_c & (~cand_c + NUM_TABLES'(1));
    rest_c   = cand_c & ~lowest_c;
    second_c = rest_c & (~rest_c + NUM_TABLES'(1));
    pick_c   = lowest_c;
`ifdef TAGE_ALLOC_LFSR_EN
    if (lfsr_q[0] && rest_c != '0) pick_c = second_c;
`endif
    tbl_alloc_o = '0;
    tbl_dec_u_o = '0;
    if (upd_c && pred_taken_q != outcome_q && prov_id_q < PW'(NUM_TABLES)) begin
      if (cand_c != '0) tbl_alloc_o = pick_c;
      else              tbl_dec_u_o = above_c;
    end
  end

  always_comb begin
    tbl_provider_o = '0;
    tbl_update_u_o = '0;
    tbl_hash_idx_o = idx_q;
    for (int j = 0; j < NUM_TABLES; j++) begin
      tbl_provider_o[j] = upd_c && (prov_id_q == PW'(j + 1));
      tbl_update_u_o[j] = tbl_provider_o[j] && (prov_pred_q != alt_pred_q);
      // Flipping the index LSB in UPDATE makes each table see prev_idx != hash_idx.
      if (upd_c) tbl_hash_idx_o[j*IDX_W] = ~idx_q[j*IDX_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      tag_q           <= '0;
      dom_q           <= INIT;
      base_q          <= 1'b0;
      prov_id_q       <= '0;
      prov_pred_q     <= 1'b0;
      alt_pred_q      <= 1'b0;
      prov_new_q      <= 1'b0;
      u_q             <= '0;
      pred_valid_q    <= 1'b0;
      pred_taken_q    <= 1'b0;
      pred_provider_q <= '0;
      outcome_q       <= 1'b0;
      use_alt_q       <= 4'd8;
    end else begin
      state_q      <= state_d;
      use_alt_q    <= use_alt_d;
      pred_valid_q <= (state_q == S_PREDICT) && !flush_i;
      if (state_q == S_IDLE && req_valid_i) begin
        idx_q  <= req_idx_i;
        tag_q  <= req_tag_i;
        dom_q  <= req_domain_i;
        base_q <= base_pred_i;
      end
      if (state_q == S_PREDICT && !flush_i) begin
        prov_id_q       <= p_id_c;
        prov_pred_q     <= p_pred_c;
        alt_pred_q      <= a_pred_c;
        prov_new_q      <= p_new_c;
        u_q             <= tbl_u_i;
        pred_taken_q    <= final_c;
        pred_provider_q <= p_id_c;
      end
      if (state_q == S_WAIT && res_valid_i && !flush_i) outcome_q <= res_taken_i;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign pred_valid_o    = pred_valid_q;
  assign pred_taken_o    = pred_taken_q;
  assign pred_provider_o = pred_provider_q;
  assign tbl_hash_tag_o  = tag_q;
  assign tbl_domain_o    = dom_q;
  assign tbl_br_result_o = outcome_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tage_ctrl.sv
// Scoreboard bench for tage_ctrl: predictions and update strobes checked against a small TAGE model.
module tb_tage_ctrl;
  import tage_ctrl_pkg::*;

  localparam int NT = 4;
  localparam int IW = 10;
  localparam int TW = 9;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [NT*IW-1:0] req_idx = '0;
  logic [NT*TW-1:0] req_tag = '0;
  domain_t req_domain = INIT;
  logic base_pred = 1'b0;
  logic pred_valid, pred_taken;
  logic [PW-1:0] pred_provider;
  logic res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic [NT*IW-1:0] hash_idx;
  logic [NT*TW-1:0] hash_tag;
  domain_t tbl_domain;
  logic br_result;
  logic [NT-1:0] s_prov, s_updu, s_dec, s_alloc;
  logic [NT-1:0] tag_hit = '0, tpred = '0, new_entry = '0;
  logic [2*NT-1:0] tu = '0;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int m_use_alt = 8;
  logic [3:0]  pred_q[$];
  logic [16:0] upd_q[$];

  tage_ctrl #(.NUM_TABLES(NT), .IDX_W(IW), .TAG_W(TW), .PW(PW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_idx_i(req_idx), .req_tag_i(req_tag), .req_domain_i(req_domain),
    .base_pred_i(base_pred),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_provider_o(pred_provider),
    .res_valid_i(res_valid), .res_taken_i(res_taken), .flush_i(flush),
    .tbl_hash_idx_o(hash_idx), .tbl_hash_tag_o(hash_tag), .tbl_domain_o(tbl_domain),
    .tbl_br_result_o(br_result), .tbl_provider_o(s_prov), .tbl_update_u_o(s_updu),
    .tbl_dec_u_o(s_dec), .tbl_alloc_o(s_alloc),
    .tbl_tag_hit_i(tag_hit), .tbl_pred_i(tpred), .tbl_u_i(tu), .tbl_new_entry_i(new_entry),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT presents a prediction or an update cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (pred_valid) begin
        chk("pred_expected", pred_q.size() != 0, 1);
        if (pred_q.size() != 0) chk("pred", {pred_taken, pred_provider}, pred_q.pop_front());
      end
      if (dbg_state == 3'd4) begin
        chk("upd_expected", upd_q.size() != 0, 1);
        if (upd_q.size() != 0)
          chk("upd_strobes", {br_result, s_prov, s_updu, s_dec, s_alloc}, upd_q.pop_front());
      end else begin
        chk("strobes_idle", {s_prov, s_updu, s_dec, s_alloc}, 16'h0);
      end
    end
  end

  // flush_at: 0 none, 1 LOOKUP, 2 PREDICT, 3 WAIT_RES.
  task automatic run_branch(input logic [3:0] hit, input logic [3:0] tp, input logic [3:0] ne,
                            input logic [7:0] u, input logic base, input logic outcome,
                            input int flush_at);
    int p, w;
    logic alt, ppred, fin, found;
    logic [NT*IW-1:0] idx, idx_flip;
    logic [NT*TW-1:0] tag;
    domain_t dom;
    logic [3:0] e_prov, e_updu, e_dec, e_alloc;

    for (int k = 0; k < NT; k++) begin
      idx[k*IW +: IW] = IW'($urandom_range(0, 1023));
      tag[k*TW +: TW] = TW'($urandom_range(0, 511));
    end
    dom = domain_t'($urandom_range(0, 3));
    p = -1;
    for (int k = NT - 1; k >= 0; k--) if (hit[k] && p < 0) p = k;
    alt = base;
    found = 1'b0;
    for (int k = p - 1; k >= 0; k--) if (hit[k] && !found) begin alt = tp[k]; found = 1'b1; end
    ppred = (p >= 0) ? tp[p] : base;
    fin = (p >= 0 && ne[p] && m_use_alt >= 8) ? alt : ppred;

    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1; req_idx = idx; req_tag = tag; req_domain = dom; base_pred = base;
    tag_hit = hit; tpred = tp; new_entry = ne; tu = u;
    if (flush_at == 0 || flush_at == 3) pred_q.push_back({fin, 3'(p + 1)});
    @(negedge clk);
    req_valid = 1'b0;
    chk("lookup_idx", hash_idx, idx);
    chk("lookup_tag", hash_tag, tag);
    chk("lookup_dom", tbl_domain, dom);
    if (flush_at == 1 || flush_at == 2) begin
      if (flush_at == 2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", req_ready, 1);
      return;
    end
    @(negedge clk);
    chk("pred_early", pred_valid, 0);
    @(negedge clk);
    chk("pred_latency", pred_valid, 1);
    if (flush_at == 3) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", req_ready, 1);
      res_valid = 1'b1; res_taken = outcome;
      @(negedge clk);
      res_valid = 1'b0;
      chk("late_res_ignored", req_ready, 1);
      return;
    end
    res_valid = 1'b1; res_taken = outcome;
    e_prov = (p >= 0) ? 4'(1 << p) : 4'h0;
    e_updu = (p >= 0 && ppred != alt) ? e_prov : 4'h0;
    e_dec = 4'h0; e_alloc = 4'h0;
    if (fin != outcome && p < NT - 1) begin
      found = 1'b0;
      for (int j = p + 1; j < NT; j++)
        if (!found && u[2*j +: 2] == 2'b00) begin e_alloc[j] = 1'b1; found = 1'b1; end
      if (!found) for (int j = p + 1; j < NT; j++) e_dec[j] = 1'b1;
    end
    upd_q.push_back({outcome, e_prov, e_updu, e_dec, e_alloc});
    @(negedge clk);
    res_valid = 1'b0;
    idx_flip = idx;
    for (int k = 0; k < NT; k++) idx_flip[k*IW] = ~idx[k*IW];
    chk("update_idx", hash_idx, idx_flip);
    @(negedge clk);
    chk("ready_after", req_ready, 1);
    if (p >= 0 && ne[p] && ppred != alt) begin
      if (alt == outcome) m_use_alt = (m_use_alt < 15) ? m_use_alt + 1 : 15;
      else                m_use_alt = (m_use_alt > 0) ? m_use_alt - 1 : 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_pred", {pred_valid, pred_taken, pred_provider}, 5'h0);
    chk("rst_strobes", {br_result, s_prov, s_updu, s_dec, s_alloc}, 17'h0);
    chk("rst_idx", hash_idx, '0);
    chk("rst_tag", hash_tag, '0);
    chk("rst_dom", tbl_domain, INIT);
    rst = 1'b0;
    @(negedge clk);

    run_branch(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 0);
    run_branch(4'b0000, 4'b0000, 4'b0000, 8'h4C, 1'b0, 1'b1, 0);
    run_branch(4'b1010, 4'b1000, 4'b0000, 8'hFF, 1'b0, 1'b1, 0);
    run_branch(4'b0001, 4'b0001, 4'b0000, 8'h08, 1'b0, 1'b0, 0);
    run_branch(4'b0010, 4'b0000, 4'b0000, 8'hD0, 1'b1, 1'b1, 0);
    run_branch(4'b1000, 4'b1000, 4'b0000, 8'h00, 1'b0, 1'b0, 0);
    // use_alt: alt correct four times (8 -> 12), then alt wrong until provider wins.
    repeat (4) run_branch(4'b0101, 4'b0001, 4'b0100, 8'h55, 1'b0, 1'b1, 0);
    chk("use_alt_model", m_use_alt, 12);
    run_branch(4'b0101, 4'b0001, 4'b0100, 8'h55, 1'b0, 1'b1, 0);
    repeat (6) run_branch(4'b0101, 4'b0001, 4'b0100, 8'h55, 1'b0, 1'b0, 0);
    run_branch(4'b0110, 4'b0010, 4'b0000, 8'h00, 1'b1, 1'b0, 1);
    run_branch(4'b0110, 4'b0010, 4'b0000, 8'h00, 1'b1, 1'b0, 2);
    run_branch(4'b0110, 4'b0010, 4'b0000, 8'h00, 1'b1, 1'b0, 3);
    run_branch(4'b0001, 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 0);
    for (int i = 0; i < 24; i++)
      run_branch(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (i % 6 == 5) ? $urandom_range(1, 3) : 0);

    repeat (3) @(negedge clk);
    chk("pred_q_drained", pred_q.size(), 0);
    chk("upd_q_drained", upd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tage_ctrl.md
Name: tage_ctrl

Overview:
- Sequences NUM_TABLES tagged TAGE tables, one branch at a time: issues the lookup, forms the final prediction, waits for the branch outcome, then drives the per-table update, useful-counter and allocation strobes.
- Sits between the fetch/branch unit and the tage_table instances.
- Guarantees that each table's registered previous-index equals the lookup index in the update cycle.

Parameters:
- NUM_TABLES, 4, number of tagged tables; table NUM_TABLES-1 has the longest history.
- IDX_W, `TAGE_IDX_WIDTH, table index width.
- TAG_W, 9, tag width.
- PW, $clog2(NUM_TABLES+1), provider id width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  lookup request
- req_ready_o  out  1  high only in IDLE
- req_idx_i  in  NUM_TABLES*IDX_W  per-table hashed index (table k at slice k)
- req_tag_i  in  NUM_TABLES*TAG_W  per-table hashed tag
- req_domain_i  in  domain_t  requesting domain
- base_pred_i  in  1  bimodal prediction, sampled with the request
- pred_valid_o  out  1  one-cycle pulse, prediction valid
- pred_taken_o  out  1  final prediction
- pred_provider_o  out  PW  0 = base, k+1 = table k
- res_valid_i  in  1  outcome valid
- res_taken_i  in  1  branch outcome
- flush_i  in  1  abandon the in-flight branch
- tbl_hash_idx_o  out  NUM_TABLES*IDX_W  to table hash_idx_i
- tbl_hash_tag_o  out  NUM_TABLES*TAG_W  to table hash_tag_i
- tbl_domain_o  out  domain_t  to every table's domain_i
- tbl_br_result_o  out  1  to every table's br_result_i
- tbl_provider_o  out  NUM_TABLES  per-table provider_i
- tbl_update_u_o  out  NUM_TABLES  per-table update_u_i
- tbl_dec_u_o  out  NUM_TABLES  per-table dec_u_i
- tbl_alloc_o  out  NUM_TABLES  per-table alloc_i
- tbl_tag_hit_i  in  NUM_TABLES  table tag_hit_o
- tbl_pred_i  in  NUM_TABLES  table prediction_o
- tbl_u_i  in  2*NUM_TABLES  table u_o
- tbl_new_entry_i  in  NUM_TABLES  table new_entry_o

Behaviour:

Reset (synchronous):
- state = IDLE; all strobes and pred_* = 0.
- tbl_hash_idx_o/tbl_hash_tag_o = 0; tbl_domain_o = INIT.
- use_alt = 4'd8.

FSM: IDLE -> LOOKUP -> PREDICT -> WAIT_RES -> UPDATE -> IDLE.
- IDLE: on req_valid_i, latch idx, tag, domain and base_pred; drive them onto the tbl_* outputs; -> LOOKUP.
- LOOKUP: hold the tbl_* outputs (table outputs register this cycle); -> PREDICT.
- PREDICT:
  - Provider P = highest k with tbl_tag_hit_i[k]. Alt A = next lower hit, else base.
  - pred_taken_o = alt if provider new_entry && use_alt[3], else provider pred. With no hit, pred_taken_o = base.
  - Latch P, provider pred, alt pred, new_entry and all u values; pulse pred_valid_o; -> WAIT_RES.
  - Prediction latency: 3 cycles from accepted request.
- WAIT_RES:
  - Hold tbl_hash_idx_o unchanged, so table prev_idx stays equal to the lookup index.
  - On res_valid_i, latch res_taken_i; -> UPDATE. res_valid_i outside WAIT_RES is ignored.
- UPDATE (exactly one cycle):
  - tbl_br_result_o = outcome.
  - tbl_hash_idx_o slice k = lookup idx XOR 1, so the table counter-update condition (prev_idx != hash_idx) holds.
  - If a provider exists: tbl_provider_o[P] = 1; tbl_update_u_o[P] = (provider pred != alt pred).
  - Allocation on mispredict (final != outcome) with P < NUM_TABLES-1:
    - Candidates = tables j > P with latched u == 0.
    - Assert tbl_alloc_o for exactly one candidate: the lowest.
    - If no candidate exists, assert tbl_dec_u_o[j] for all j > P.
  - use_alt: when provider new_entry and provider pred != alt pred, increment (saturate 15) if alt was correct, else decrement (saturate 0).
  - -> IDLE.
- Strobes are zero in every state except UPDATE.

Boundaries:
- flush_i in LOOKUP, PREDICT or WAIT_RES -> IDLE next cycle, with no strobes and no pred_valid_o.
- flush_i in UPDATE is ignored.
- Provider = top table with mispredict: no allocation and no dec_u.

Optional Feature:
- Macro TAGE_ALLOC_LFSR_EN: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle.
- With the macro: when two or more candidates exist and LFSR[0] = 1, allocate the second-lowest candidate instead of the lowest.
- Without the macro: always allocate the lowest candidate; no LFSR state exists.

Test Plan:
- Reset, then request with no tag hits, base_pred_i = 1 -> pred_valid_o at cycle 3, pred_taken_o = 1, pred_provider_o = 0.
- Hits in tables 1 and 3 (preds 0 / 1), new_entry = 0 -> pred_taken_o = 1, provider = 4; outcome 1 -> UPDATE: tbl_provider_o = 4'b1000, tbl_update_u_o = 4'b1000, no alloc.
- Provider = table 0 mispredicts; u of tables 1..3 = 2,0,0 -> tbl_alloc_o = 4'b0100, tbl_dec_u_o = 0; during UPDATE tbl_hash_idx_o slice = lookup idx ^ 1.
- Provider = table 1 mispredicts; u of tables 2,3 = 1,3 -> tbl_alloc_o = 0, tbl_dec_u_o = 4'b1100.
- Provider new_entry with alt correct four times from reset -> use_alt reaches 12; next such lookup selects the alt prediction.
- flush_i asserted in WAIT_RES -> back in IDLE next cycle, req_ready_o = 1, no strobes; a later res_valid_i is ignored.
